// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single in-flight ROM read tracking, 2-entry {inst, pc} FIFO to decode.
// Define FETCH_ADDR_CHECK_EN to compile in the misaligned / out-of-ROM fetch-address fault.
module inst_fetch #(
  parameter int unsigned       ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] ROM_LAST = ADDR_W'('h48),
  localparam int unsigned      INST_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [INST_W-1:0] romInst,
  input  logic              redirectValid,
  input  logic [ADDR_W-1:0] redirectTarget,
  output logic              instValid,
  input  logic              instReady,
  output logic [INST_W-1:0] instOut,
  output logic [ADDR_W-1:0] instPc,
  output logic              fault
);

  logic [ADDR_W-1:0] pc;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_pc;
  logic [1:0]        count;
  logic [INST_W-1:0] head_inst, tail_inst;
  logic [ADDR_W-1:0] head_pc, tail_pc;
  logic              fault_q;

  logic       deq, push, can_issue, issue, set_fault;
  logic [2:0] occ;

  // Issue / push / fault decisions for this edge
  always_comb begin
    deq       = (count != 2'd0) && instReady;
    push      = inflight && !redirectValid;
    occ       = 3'(count) + 3'(inflight) - 3'(deq);
    can_issue = !redirectValid && !fault_q && (occ < 3'd2);
    issue     = can_issue;
    set_fault = 1'b0;
`ifdef FETCH_ADDR_CHECK_EN
    if ((pc[1:0] != 2'b00) || (pc > ROM_LAST)) begin
      issue     = 1'b0;
      set_fault = can_issue;
    end
`endif
  end

  // PC and in-flight read tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirectValid) begin
      pc       <= redirectTarget;
      inflight <= 1'b0;
    end else if (issue) begin
      pc          <= pc + ADDR_W'(4);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight <= 1'b0;
    end
  end

  // Shift-style FIFO: the head registers feed decode directly and keep their value when empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= 2'd0;
      head_inst <= '0;
      head_pc   <= '0;
      tail_inst <= '0;
      tail_pc   <= '0;
    end else if (redirectValid) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, deq};
      if (deq) begin
        if (count == 2'd2) begin
          head_inst <= tail_inst;
          head_pc   <= tail_pc;
          if (push) begin
            tail_inst <= romInst;
            tail_pc   <= inflight_pc;
          end
        end else if (push) begin
          head_inst <= romInst;
          head_pc   <= inflight_pc;
        end
      end else if (push) begin
        if (count == 2'd0) begin
          head_inst <= romInst;
          head_pc   <= inflight_pc;
        end else begin
          tail_inst <= romInst;
          tail_pc   <= inflight_pc;
        end
      end
    end
  end

`ifdef FETCH_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             fault_q <= 1'b0;
    else if (redirectValid) fault_q <= 1'b0;
    else if (set_fault)     fault_q <= 1'b1;
  end
`else
  logic unused_rom_last;
  assign fault_q         = 1'b0;
  assign unused_rom_last = ^{ROM_LAST, set_fault};
`endif

  // The issue rule must keep a push from ever landing on a full FIFO
  assert property (@(posedge clk) disable iff (!rst_n) !(push && (count == 2'd2) && !deq));

  assign romAddr   = pc;
  assign instValid = (count != 2'd0);
  assign instOut   = head_inst;
  assign instPc    = head_pc;
  assign fault     = fault_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, corner sequences, and a random run
// scored against an in-order instruction-stream model.
module tb_inst_fetch;
  localparam logic [7:0] ROM_LAST = 8'h48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  romAddr;
  logic [31:0] romInst;
  logic        redirectValid;
  logic [7:0]  redirectTarget;
  logic        instValid;
  logic        instReady;
  logic [31:0] instOut;
  logic [7:0]  instPc;
  logic        fault;

  int checks = 0;
  int passes = 0;

  logic [31:0] rom [64];
  logic [31:0] rom_q = '0;

  inst_fetch #(.ADDR_W(8), .RESET_PC(8'h00), .ROM_LAST(ROM_LAST)) dut (
    .clk(clk), .rst_n(rst_n), .romAddr(romAddr), .romInst(romInst),
    .redirectValid(redirectValid), .redirectTarget(redirectTarget),
    .instValid(instValid), .instReady(instReady), .instOut(instOut),
    .instPc(instPc), .fault(fault)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: address sampled on an edge, word available until the next edge
  always @(posedge clk) rom_q <= rom[romAddr[7:2]];
  assign romInst = rom_q;

  typedef struct {
    logic        ready;
    logic        redir;
    logic [7:0]  tgt;
    logic        exp_valid;
    logic [7:0]  exp_pc;
    logic [7:0]  exp_addr;
    logic [31:0] exp_inst;
  } vec_t;

  vec_t        tbl [16];
  logic [7:0]  got_pc [$];
  logic [31:0] got_inst [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  exp_next;
  logic        rnd_ready, rnd_redir, in_range;
  logic [7:0]  rnd_tgt;
  int          since_redir, hs;

  function automatic logic [31:0] rom_word(input logic [7:0] a);
    return rom[a[7:2]];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %08h expected %08h", name, act, exp);
    else passes++;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input int n);
    got_pc.delete();
    got_inst.delete();
    for (int i = 0; i < n; i++) begin
      if (instValid && instReady) begin
        got_pc.push_back(instPc);
        got_inst.push_back(instOut);
      end
      step();
    end
  endtask

  task automatic compare_stream(input string name);
    chk({name, "_len"}, 32'(got_pc.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_pc.size()) begin
        chk({name, "_pc"}, 32'(got_pc[i]), 32'(exp_q[i]));
        chk({name, "_inst"}, got_inst[i], rom_word(exp_q[i]));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA5A50000 | 32'(i);
    rom[0]  = 32'h00450693;
    rom[1]  = 32'h00100713;
    rom[7]  = 32'hffc62883;
    rom[12] = 32'hfe0796e3;

    // ready, redir, tgt, exp_valid, exp_pc, exp_addr, exp_inst (outputs after each edge)
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'h04, 32'h0};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 8'h08, 32'h00450693};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 8'h0C, 32'h00100713};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 8'h0C, 32'h00100713};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 8'h0C, 32'h00100713};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 8'h04, 8'h0C, 32'h00100713};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h08, 8'h10, rom_word(8'h08)};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h0C, 8'h14, rom_word(8'h0C)};
    tbl[8]  = '{1'b1, 1'b1, 8'h1C, 1'b0, 8'h0C, 8'h1C, rom_word(8'h0C)};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h0C, 8'h20, rom_word(8'h0C)};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h1C, 8'h24, 32'hffc62883};
    tbl[11] = '{1'b1, 1'b1, 8'h10, 1'b0, 8'h1C, 8'h10, 32'hffc62883};
    tbl[12] = '{1'b1, 1'b1, 8'h30, 1'b0, 8'h1C, 8'h30, 32'hffc62883};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h1C, 8'h34, 32'hffc62883};
    tbl[14] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h30, 8'h38, 32'hfe0796e3};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h34, 8'h3C, rom_word(8'h34)};

    rst_n = 1'b0;
    instReady = 1'b0;
    redirectValid = 1'b0;
    redirectTarget = 8'h00;
    repeat (3) step();
    chk("rst_valid", 32'(instValid), 32'd0);
    chk("rst_addr", 32'(romAddr), 32'h00);
    chk("rst_inst", instOut, 32'h0);
    chk("rst_pc", 32'(instPc), 32'h0);
    chk("rst_fault", 32'(fault), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      instReady      = tbl[i].ready;
      redirectValid  = tbl[i].redir;
      redirectTarget = tbl[i].tgt;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(instValid), 32'(tbl[i].exp_valid));
      chk($sformatf("vec%0d_addr", i), 32'(romAddr), 32'(tbl[i].exp_addr));
      chk($sformatf("vec%0d_pc", i), 32'(instPc), 32'(tbl[i].exp_pc));
      chk($sformatf("vec%0d_inst", i), instOut, tbl[i].exp_inst);
    end

    // Fill both entries, then reset mid-cycle
    instReady = 1'b0;
    redirectValid = 1'b0;
    step();
    chk("full_valid", 32'(instValid), 32'd1);
    chk("full_addr", 32'(romAddr), 32'h3C);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(instValid), 32'd0);
    chk("midrst_addr", 32'(romAddr), 32'h00);
    chk("midrst_pc", 32'(instPc), 32'h00);
    chk("midrst_inst", instOut, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    instReady = 1'b1;
    step();
    chk("restart_e1_valid", 32'(instValid), 32'd0);
    chk("restart_e1_addr", 32'(romAddr), 32'h04);
    step();
    chk("restart_e2_valid", 32'(instValid), 32'd1);
    chk("restart_e2_pc", 32'(instPc), 32'h00);
    chk("restart_e2_inst", instOut, 32'h00450693);

    // Run across the last populated word
    redirectValid = 1'b1;
    redirectTarget = 8'h40;
    step();
    redirectValid = 1'b0;
    collect(8);
    exp_q.delete();
`ifdef FETCH_ADDR_CHECK_EN
    exp_q = '{8'h40, 8'h44, 8'h48};
    compare_stream("edge");
    chk("edge_fault", 32'(fault), 32'd1);
    chk("edge_addr_hold", 32'(romAddr), 32'h4C);
`else
    exp_q = '{8'h40, 8'h44, 8'h48, 8'h4C, 8'h50, 8'h54};
    compare_stream("edge");
    chk("edge_fault", 32'(fault), 32'd0);
    chk("edge_addr_run", 32'(romAddr), 32'h60);
`endif
    redirectValid = 1'b1;
    redirectTarget = 8'h00;
    step();
    redirectValid = 1'b0;
    chk("recover_fault", 32'(fault), 32'd0);
    step();
    step();
    chk("recover_valid", 32'(instValid), 32'd1);
    chk("recover_pc", 32'(instPc), 32'h00);
    chk("recover_inst", instOut, 32'h00450693);

`ifndef FETCH_ADDR_CHECK_EN
    // PC wraps modulo 256
    redirectValid = 1'b1;
    redirectTarget = 8'hF8;
    step();
    redirectValid = 1'b0;
    collect(5);
    exp_q = '{8'hF8, 8'hFC, 8'h00};
    compare_stream("wrap");
`endif

    // Random run: decode must see an in-order stream restarting at each redirect target
    exp_next = 8'h00;
    since_redir = 5;
    hs = 0;
    for (int n = 0; n < 3000; n++) begin
      rnd_ready = (n == 0) ? 1'b0 : ($urandom_range(0, 9) < 7);
      rnd_redir = (n == 0) ? 1'b1 : ($urandom_range(0, 99) < 8);
      rnd_tgt   = (n == 0) ? 8'h00 : 8'(4 * $urandom_range(0, 18));
      instReady = rnd_ready;
      redirectValid = rnd_redir;
      redirectTarget = rnd_tgt;
`ifdef FETCH_ADDR_CHECK_EN
      in_range = (exp_next <= ROM_LAST);
`else
      in_range = 1'b1;
`endif
      if (since_redir == 0) begin
        chk("rand_flush_valid", 32'(instValid), 32'd0);
        chk("rand_flush_fault", 32'(fault), 32'd0);
      end
      if (instValid && instReady) begin
        chk("rand_pc", 32'(instPc), 32'(exp_next));
        chk("rand_inst", instOut, rom_word(exp_next));
`ifdef FETCH_ADDR_CHECK_EN
        chk("rand_range", 32'(instPc <= ROM_LAST), 32'd1);
`endif
        exp_next = exp_next + 8'd4;
        hs++;
      end else if (instReady && since_redir >= 2 && in_range) begin
        chk("rand_stall", 32'(instValid), 32'd1);
      end
      if (rnd_redir) begin
        exp_next = rnd_tgt;
        since_redir = 0;
      end else if (since_redir < 5) begin
        since_redir++;
      end
      step();
    end
    chk("rand_activity", 32'(hs > 200), 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
